// File: rtl/bshift_pkg.sv
// Shared types and widths for the bshift_arb round-robin rotate sequencer.
package bshift_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
  localparam int ID_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } bsa_state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } grant_t;

endpackage

// File: rtl/rot8_core.sv
// Combinational 8-bit rotator: dir=0 rotates right, dir=1 rotates left.
module rot8_core
  import bshift_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [AMT_W-1:0]  amt,
  input  logic              dir,
  output logic [DATA_W-1:0] dout
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dout = '0;
    // Index arithmetic is 3 bits wide, so the wrap modulo 8 falls out for free.
    for (int i = 0; i < DATA_W; i++) begin
      if (dir) dout[i] = din[3'(i) - amt];
      else     dout[i] = din[3'(i) + amt];
    end
  end

endmodule

// File: rtl/bshift_arb.sv
// Round-robin arbiter sharing one rot8_core between N_REQ requesters, with a
// registered valid/ready response. Define BSHIFT_ARB_DIR_EN to add per-request rotate-left.
module bshift_arb
  import bshift_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [AMT_W*N_REQ-1:0]  req_amt,
`ifdef BSHIFT_ARB_DIR_EN
  input  logic [N_REQ-1:0]        req_dir,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id
);

  bsa_state_t        state_q, state_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  grant_t            grant;
  logic              can_acc;
  logic              xfer;
  logic [DATA_W-1:0] win_data;
  logic [AMT_W-1:0]  win_amt;
  logic              win_dir;
  logic [DATA_W-1:0] rot_out;

  // First valid requester at or after ptr, wrapping modulo N_REQ. Scanning
  // downward in offset lets the closest candidate overwrite farther ones.
  function automatic grant_t rr_pick(input logic [N_REQ-1:0] valid,
                                     input logic [ID_W-1:0]  ptr);
    grant_t g;
    int     k;
    g = '{found: 1'b0, idx: '0};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (valid[k]) begin
        g.found = 1'b1;
        g.idx   = ID_W'(k);
      end
    end
    return g;
  endfunction

  always_comb begin
    grant    = rr_pick(req_valid, ptr_q);
    can_acc  = (state_q == IDLE) || rsp_ready;
    xfer     = can_acc && grant.found;
    req_ready = '0;
    win_data = '0;
    win_amt  = '0;
    win_dir  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      // Grant is gated by rst so clients see no accept while reset is held.
      req_ready[k] = xfer && !rst && (grant.idx == ID_W'(k));
      if (grant.idx == ID_W'(k)) begin
        win_data = req_data[DATA_W*k +: DATA_W];
        win_amt  = req_amt[AMT_W*k +: AMT_W];
`ifdef BSHIFT_ARB_DIR_EN
        win_dir  = req_dir[k];
`endif
      end
    end
  end

  rot8_core u_rot (
    .din  (win_data),
    .amt  (win_amt),
    .dir  (win_dir),
    .dout (rot_out)
  );

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      // A load in FULL retires the old result on the same edge.
      state_d    = FULL;
      rsp_data_d = rot_out;
      rsp_id_d   = grant.idx;
      ptr_d      = (grant.idx == ID_W'(N_REQ - 1)) ? '0 : grant.idx + 1'b1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_bshift_arb.sv
// Scoreboard bench for bshift_arb: a 2-requester instance checked every cycle
// against a reference model, plus a 3-requester instance for pointer wrap.
module tb_bshift_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data;
  logic [5:0]  req_amt;
  logic [1:0]  req_dir;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;

  logic [2:0]  v3;
  logic [2:0]  ready3;
  logic [23:0] d3;
  logic [8:0]  a3;
  logic [2:0]  dir3;
  logic        rv3;
  logic        rr3;
  logic [7:0]  rd3;
  logic [1:0]  rid3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;
  exp_t sb[$];

  logic       m_full;
  int         m_ptr;
  int         mw;
  logic [1:0] exp_rdy;
  logic       m_can;
  logic       m_left;

  bshift_arb #(.N_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
`ifdef BSHIFT_ARB_DIR_EN
    .req_dir   (req_dir),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  bshift_arb #(.N_REQ(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v3),
    .req_ready (ready3),
    .req_data  (d3),
    .req_amt   (a3),
`ifdef BSHIFT_ARB_DIR_EN
    .req_dir   (dir3),
`endif
    .rsp_valid (rv3),
    .rsp_ready (rr3),
    .rsp_data  (rd3),
    .rsp_id    (rid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_rot(input logic [7:0] x, input int amt, input logic left);
    logic [7:0] r;
    int src;
    for (int i = 0; i < 8; i++) begin
      src  = left ? (i - amt + 8) % 8 : (i + amt) % 8;
      r[i] = x[src];
    end
    return r;
  endfunction

  // Reference model evaluated just before each rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      check("rst_req_ready_mon", req_ready, 2'b00);
      check("rst_rsp_valid_mon", rsp_valid, 1'b0);
    end else begin
      m_can = !m_full || rsp_ready;
      mw    = -1;
      for (int i = 0; i < 2; i++) begin
        if (mw < 0 && req_valid[(m_ptr + i) % 2]) mw = (m_ptr + i) % 2;
      end
      exp_rdy = (m_can && mw >= 0) ? 2'(1 << mw) : 2'b00;
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, m_full);
      if (m_full && sb.size() > 0) begin
        check("rsp_data", rsp_data, sb[0].data);
        check("rsp_id", rsp_id, sb[0].id);
        if (rsp_ready) void'(sb.pop_front());
      end
      if (m_can && mw >= 0) begin
`ifdef BSHIFT_ARB_DIR_EN
        m_left = req_dir[mw];
`else
        m_left = 1'b0;
`endif
        sb.push_back('{data: model_rot(req_data[8*mw +: 8], int'(req_amt[3*mw +: 3]), m_left),
                       id: 2'(mw)});
        m_ptr  = (mw + 1) % 2;
        m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_amt = '0; req_dir = '0; rsp_ready = 1'b0;
    v3 = '0; d3 = '0; a3 = '0; dir3 = '0; rr3 = 1'b1;
    repeat (2) step();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_id", rsp_id, 2'd0);
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    req_valid = 2'b00;
    rst = 1'b0;
    step();

    // Single requester, then amt=0 pass-through.
    req_data[7:0] = 8'h81; req_amt[2:0] = 3'd1; rsp_ready = 1'b1; req_valid = 2'b01;
    #1;
    check("first_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    check("single_amt1_data", rsp_data, 8'hC0);
    check("single_amt1_id", rsp_id, 2'd0);
    req_amt[2:0] = 3'd0; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("single_amt0_data", rsp_data, 8'h81);
`ifdef BSHIFT_ARB_DIR_EN
    req_amt[2:0] = 3'd1; req_dir[0] = 1'b1; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("dir_left_data", rsp_data, 8'h03);
    req_dir[0] = 1'b0; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("dir_right_data", rsp_data, 8'hC0);
`endif
    step();

    // Contention: ptr is 1 after the last grant to requester 0.
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_data = 16'($urandom); req_amt = 6'($urandom); req_dir = 2'($urandom);
      step();
      check("contend_valid", rsp_valid, 1'b1);
      check("contend_id", rsp_id, 2'((i + 1) % 2));
    end

    // Backpressure with a result pending and both requesters still valid.
    rsp_ready = 1'b0;
    repeat (3) begin
      step();
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_handoff_valid", rsp_valid, 1'b1);

    // Random traffic, checked by the model.
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_data  = 16'($urandom);
      req_amt   = 6'($urandom);
      req_dir   = 2'($urandom);
      step();
    end

    // Reset while a result is held.
    req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (2) step();
    req_data[7:0] = 8'h5A; req_amt[2:0] = 3'd2; req_valid = 2'b01; rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    check("pre_rst_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", rsp_valid, 1'b0);
    check("async_rst_data", rsp_data, 8'h00);
    check("async_rst_id", rsp_id, 2'd0);
    check("async_rst_ready", req_ready, 2'b00);
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    #1;
    check("post_rst_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    check("post_rst_id", rsp_id, 2'd0);

    // Three requesters: drive ptr to 2, then requesters 0 and 2 contend.
    d3[15:8] = 8'h0F; a3[5:3] = 3'd4; v3 = 3'b010;
    step();
    v3 = 3'b000;
    check("wrap_setup_id", rid3, 2'd1);
    check("wrap_setup_data", rd3, 8'hF0);
    d3[7:0] = 8'h01; a3[2:0] = 3'd1; d3[23:16] = 8'h02; a3[8:6] = 3'd1; v3 = 3'b101;
    #1;
    check("wrap_grant2", ready3, 3'b100);
    step();
    v3 = 3'b001;
    check("wrap_id2", rid3, 2'd2);
    check("wrap_data2", rd3, 8'h01);
    #1;
    check("wrap_grant0", ready3, 3'b001);
    step();
    v3 = 3'b000;
    check("wrap_id0", rid3, 2'd0);
    check("wrap_data0", rd3, 8'h80);

    // Drain whatever the model still expects, within a bounded cycle budget.
    req_valid = 2'b00; rsp_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    step();
    check("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bshift_arb.md
# bshift_arb

Round-robin arbiter and sequencer that shares one 8-bit rotate-right datapath between `N_REQ` requesters. Each requester presents a byte and a 3-bit rotate amount on a valid/ready handshake. The block grants one requester per cycle, registers the rotated result and returns it tagged with the requester index on a single valid/ready response port. It sits between client blocks and the combinational rotator, which it instantiates internally.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero.
- `req_data`  in  8*N_REQ  operand byte; requester k uses bits [8k+7:8k].
- `req_amt`  in  3*N_REQ  rotate amount; requester k uses bits [3k+2:3k].
- `req_dir`  in  N_REQ  rotate direction, 1 = left. Present only with `BSHIFT_ARB_DIR_EN`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  8  rotated byte.
- `rsp_id`  out  2  index of the requester that owns `rsp_data`.

## Operation
- FSM has two states:
  - IDLE: output register empty.
  - FULL: result held, `rsp_valid`=1.
- Accept condition: `can_acc` = (state==IDLE) or (state==FULL and `rsp_ready`).
- Arbitration:
  - When `can_acc` is true, the winner is the first k with `req_valid[k]`=1, scanning upward from `ptr` and wrapping modulo N_REQ.
  - `req_ready[k]`=1 for the winner only. It is combinational from `req_valid`, `ptr`, state and `rsp_ready`.
  - A transfer happens when `req_valid[k]` and `req_ready[k]` are both 1.
- On a transfer:
  - `rsp_data` <= rotate-right(`req_data[k]`, `req_amt[k]`), where out[i] = in[(i+amt) mod 8].
  - `rsp_id` <= k.
  - `ptr` <= (k+1) mod N_REQ.
  - state <= FULL.
- FULL with `rsp_ready`=1 and no transfer: state <= IDLE. `rsp_data` and `rsp_id` keep their last values.
- FULL with `rsp_ready`=0: all outputs hold and `req_ready`=0.
- `ptr` does not change on cycles with no transfer.
- Request inputs are sampled only at the transfer edge. Changing them while not granted has no effect.
- amt=0 passes the byte through unchanged.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_data`=8'h00, `rsp_id`=0.
  - `req_ready`=0 combinationally while `rst` is asserted.
  - `ptr`=0, state=IDLE.
- Latency: request accepted at edge T gives `rsp_valid`=1 after edge T.
- Throughput: one result per cycle when `rsp_ready` is held at 1.
- Back-to-back: in FULL with `rsp_ready`=1 and a pending request, the old result retires and the new one loads on the same edge. `rsp_valid` stays 1.
- Simultaneous requests: exactly one grant per cycle. The losers keep `req_valid` asserted and win in later cycles in rotating order.
- Reset asserted mid-response: the pending result is discarded and `rsp_valid` drops immediately (asynchronous). Nothing is replayed.
- Stability: while `rsp_valid`=1 and `rsp_ready`=0, `rsp_data` and `rsp_id` are stable.

## Configuration
- Macro: `BSHIFT_ARB_DIR_EN`.
- Defined:
  - The `req_dir` port exists.
  - dir=1 performs rotate-left by amt: out[i] = in[(i-amt) mod 8].
  - The direction bit is captured with the operand at transfer.
- Undefined:
  - The `req_dir` port is absent.
  - All operations rotate right.

## Structure
- Package `bshift_pkg` holds:
  - `DATA_W`=8 and `AMT_W`=3.
  - The state enum `bsa_state_t` {IDLE, FULL}.
  - The `ID_W`=2 constant.
- Sub-module `rot8_core`: combinational 8-bit rotator (in, amt, dir → out). It has no clock and is instantiated once, between the winner mux and the output register.
- The arbiter uses a `ptr`-relative priority scan, written as a function in `bshift_arb`.

## Test plan
- Reset: assert `rst` mid-run. Check `rsp_valid`=0, `rsp_data`=8'h00, `rsp_id`=0 and `req_ready`=0 at once. After release, the first grant goes to requester 0.
- Single request: req0 data=8'h81, amt=1, `rsp_ready`=1. Expect `rsp_data`=8'hC0 and `rsp_id`=0 one cycle after the transfer. Then with amt=0, expect 8'h81.
- Contention: N_REQ=2, both requesters valid continuously with `rsp_ready`=1. Grants alternate 0,1,0,1 and `rsp_valid` stays 1 every cycle after the first.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with a result pending. `rsp_data`/`rsp_id` stay stable and `req_ready`=0. On release, the same-edge handoff loads the next request.
- Wrap: N_REQ=3 with `ptr`=2; requesters 0 and 2 valid. Requester 2 is granted first, then requester 0.
- With `BSHIFT_ARB_DIR_EN`: data=8'h81, amt=1, dir=1 gives 8'h03. With dir=0 it gives 8'hC0.
